// File: rtl/unidade_controle_jogo.sv
// Game control unit: Moore FSM sequencing the memory game's round/play flow.
// In: clock, reset (async, active-high), iniciar, jogada_feita, jogada_correta,
//     enderecoIgualRodada, fimCR, timeout, timeout_jogada_inicial.
// Out: datapath controls (zeraR..grava), pronto/ganhou/perdeu/db_timeout,
//      db_estado (current 4-bit state code).
module unidade_controle_jogo (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimCR,
  input  logic       timeout,
  input  logic       timeout_jogada_inicial,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraCR,
  output logic       contaCR,
  output logic       zeraCE,
  output logic       contaCE,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraTI,
  output logic       contaTI,
  output logic       grava,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    MOSTRA        = 4'd2,
    ESPERA        = 4'd3,
    REGISTRA      = 4'd4,
    COMPARA       = 4'd5,
    PROX_JOGADA   = 4'd6,
    ESPERA_NOVA   = 4'd7,
    GRAVA         = 4'd8,
    PROX_RODADA   = 4'd9,
    REGISTRA_NOVA = 4'd10,
    FIM_ACERTO    = 4'd11,
    FIM_ERRO      = 4'd12,
    FIM_TIMEOUT   = 4'd13
  } estado_t;

  estado_t estado_q;
  estado_t estado_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:
        if (iniciar) estado_d = PREPARA;
      PREPARA:
        estado_d = MOSTRA;
      MOSTRA:
        if (timeout_jogada_inicial) estado_d = ESPERA;
      // A play arriving on the same edge as the timeout is honoured.
      ESPERA:
        if (jogada_feita) estado_d = REGISTRA;
        else if (timeout) estado_d = FIM_TIMEOUT;
      REGISTRA:
        estado_d = COMPARA;
      COMPARA:
        if (!jogada_correta)
          estado_d = FIM_ERRO;
        else if (enderecoIgualRodada && fimCR)
          estado_d = FIM_ACERTO;
        else if (enderecoIgualRodada)
          estado_d = ESPERA_NOVA;
        else
          estado_d = PROX_JOGADA;
      PROX_JOGADA:
        estado_d = ESPERA;
      ESPERA_NOVA:
        if (jogada_feita) estado_d = REGISTRA_NOVA;
        else if (timeout) estado_d = FIM_TIMEOUT;
      // Extra cycle so grava lands while the buttons are still held.
      REGISTRA_NOVA:
        estado_d = GRAVA;
      GRAVA:
        estado_d = PROX_RODADA;
      PROX_RODADA:
        estado_d = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
        if (iniciar) estado_d = PREPARA;
      default:
        estado_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraR      = 1'b0;
    registraR  = 1'b0;
    zeraCR     = 1'b0;
    contaCR    = 1'b0;
    zeraCE     = 1'b0;
    contaCE    = 1'b0;
    zeraT      = 1'b0;
    contaT     = 1'b0;
    zeraTI     = 1'b0;
    contaTI    = 1'b0;
    grava      = 1'b0;
    pronto     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    db_timeout = 1'b0;
    case (estado_q)
      PREPARA: begin
        zeraR  = 1'b1;
        zeraCR = 1'b1;
        zeraCE = 1'b1;
        zeraT  = 1'b1;
        zeraTI = 1'b1;
      end
      MOSTRA:      contaTI = 1'b1;
      ESPERA:      contaT  = 1'b1;
      REGISTRA: begin
        registraR = 1'b1;
        zeraT     = 1'b1;
      end
      PROX_JOGADA: contaCE = 1'b1;
      ESPERA_NOVA: contaT  = 1'b1;
      GRAVA: begin
        grava = 1'b1;
        zeraT = 1'b1;
      end
      PROX_RODADA: begin
        contaCR = 1'b1;
        zeraCE  = 1'b1;
        zeraT   = 1'b1;
      end
      FIM_ACERTO: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: doc/unidade_controle_jogo.md
UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clock  input  1  single system clock, all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces state INICIAL immediately.
REQ-004 iniciar  input  1  start/restart request, level-sampled.
REQ-005 jogada_feita  input  1  one-cycle pulse, player pressed a button.
REQ-006 jogada_correta  input  1  registered play equals memory word.
REQ-007 enderecoIgualRodada  input  1  address counter equals round counter.
REQ-008 fimCR  input  1  round counter at 15 (last round).
REQ-009 timeout  input  1  play timeout counter expired.
REQ-010 timeout_jogada_inicial  input  1  initial-display timer expired.
REQ-011 zeraR, registraR, zeraCR, contaCR, zeraCE, contaCE, zeraT, contaT, zeraTI, contaTI, grava  output  1 each  datapath controls.
REQ-012 pronto  output  1  game over (any end state).
REQ-013 ganhou  output  1  all 16 rounds completed.
REQ-014 perdeu  output  1  wrong play or timeout.
REQ-015 db_timeout  output  1  loss caused by timeout.
REQ-016 db_estado  output  4  current state code.

Function
REQ-017 Moore FSM; every output is decoded from current state only; any output not listed for a state is 0.
REQ-018 Codes/outputs: INICIAL=0 (none); PREPARA=1 (zeraR, zeraCR, zeraCE, zeraT, zeraTI); MOSTRA=2 (contaTI); ESPERA=3 (contaT); REGISTRA=4 (registraR, zeraT); COMPARA=5 (none); PROX_JOGADA=6 (contaCE); ESPERA_NOVA=7 (contaT); GRAVA=8 (grava, zeraT); PROX_RODADA=9 (contaCR, zeraCE, zeraT); REGISTRA_NOVA=10 (none); FIM_ACERTO=11 (pronto, ganhou); FIM_ERRO=12 (pronto, perdeu); FIM_TIMEOUT=13 (pronto, perdeu, db_timeout); codes 14-15 unused.
REQ-019 INICIAL: iniciar=1 -> PREPARA, else stay.
REQ-020 PREPARA -> MOSTRA unconditionally (one cycle).
REQ-021 MOSTRA: timeout_jogada_inicial=1 -> ESPERA, else stay.
REQ-022 ESPERA: jogada_feita=1 -> REGISTRA; else timeout=1 -> FIM_TIMEOUT; else stay; jogada_feita wins over simultaneous timeout.
REQ-023 REGISTRA -> COMPARA unconditionally.
REQ-024 COMPARA priority: jogada_correta=0 -> FIM_ERRO; else enderecoIgualRodada=1 and fimCR=1 -> FIM_ACERTO; else enderecoIgualRodada=1 -> ESPERA_NOVA; else PROX_JOGADA.
REQ-025 PROX_JOGADA -> ESPERA unconditionally.
REQ-026 ESPERA_NOVA: jogada_feita=1 -> REGISTRA_NOVA; else timeout=1 -> FIM_TIMEOUT; else stay; jogada_feita wins.
REQ-027 REGISTRA_NOVA -> GRAVA; grava therefore asserts exactly one cycle, two cycles after the jogada_feita pulse, while buttons are still held.
REQ-028 GRAVA -> PROX_RODADA; PROX_RODADA -> ESPERA.
REQ-029 End states hold outputs; iniciar=1 -> PREPARA (restart without reset), else stay.
REQ-030 Unused codes -> INICIAL on next clock.
REQ-031 Round latency: after last correct compare of round N, contaCR asserts exactly 4 cycles after leaving COMPARA-to-ESPERA_NOVA plus wait for the new play.

Reset
REQ-032 reset=1 sets state INICIAL asynchronously; all outputs 0, db_estado=0, within the same cycle, without a clock edge.
REQ-033 reset mid-game (any state) aborts; no grava, contaCR or contaCE pulse is issued after reset asserts.
REQ-034 After reset releases, the FSM leaves INICIAL only on a clock edge with iniciar=1.

Verification
REQ-035 Reset idle: reset=1 then 0, iniciar=0 for 10 cycles -> db_estado=0, all outputs 0.
REQ-036 Start: iniciar=1 one cycle -> db_estado 1, then 2 with contaTI=1 until timeout_jogada_inicial=1 -> 3.
REQ-037 Round 0 correct: in ESPERA pulse jogada_feita, jogada_correta=1, enderecoIgualRodada=1, fimCR=0 -> states 4,5,7; pulse jogada_feita -> 10,8 (grava=1 one cycle),9 (contaCR=1),3.
REQ-038 Wrong play: from ESPERA pulse jogada_feita with jogada_correta=0 -> 4,5,12; pronto=1, perdeu=1 held; iniciar=1 -> 1.
REQ-039 Timeout vs play: in ESPERA assert timeout=1 alone -> 13, db_timeout=1; repeat with timeout=1 and jogada_feita=1 same cycle -> 4.
REQ-040 Win and async reset: in COMPARA with jogada_correta=1, enderecoIgualRodada=1, fimCR=1 -> 11, ganhou=1; assert reset between edges -> db_estado=0 immediately.
